multi_bank_dpram_ctrl: RTL
==========================

// Module: multi_bank_dpram_ctrl
// PURPOSE
//  Parametrised multi-bank true dual-port RAM controller, single clock. Generalises the fixed
//  4-bank controller to NUM_BANKS banks with per-bank enable decode, latency-tracked read
//  return muxing, read-valid strobes, reset, and same-address write-collision resolution.
//  Sits between the port-A/port-B requesters and the bank storage arrays.
// PARAMETERS
//  ADDR_WIDTH     12  full word-address width, both ports
//  DATA_WIDTH      8  data word width
//  NUM_BANKS       4  bank count; power of two, >=2; BANK_BITS = $clog2(NUM_BANKS)
//  READ_LATENCY    3  cycles from request edge to o_dout*/o_valid*; >=1
//  WRITE_LATENCY   3  cycles from request edge to array commit; >=1
// PORTS
//  i_clk     in   1           single clock for both ports and all banks
//  i_rst     in   1           asynchronous, active-high reset
//  i_ena     in   1           port A request enable
//  i_wea     in   1           port A write (1) / read (0); ignored if i_ena=0
//  i_addra   in   ADDR_WIDTH  port A address; top BANK_BITS select bank
//  i_dina    in   DATA_WIDTH  port A write data
//  o_douta   out  DATA_WIDTH  port A read data
//  o_valida  out  1           port A read data valid, 1-cycle strobe per read
//  i_enb, i_web, i_addrb, i_dinb  in   same as port A, for port B
//  o_doutb, o_valid   out         same as port A, for port B (o_validb)
//  o_wr_collision     out 1   pulses 1 cycle when A and B commit to same address on same edge
// BEHAVIOUR
//  - Decode: bank = addr[ADDR_WIDTH-1 -: BANK_BITS]; offset = addr[ADDR_WIDTH-BANK_BITS-1:0];
//    bank depth 2^(ADDR_WIDTH-BANK_BITS). Only the selected bank's enable asserts; others idle.
//  - Request sampled at rising edge n when i_en*=1. Each port has its own pipeline.
//  - Write: {bank,offset,data} travel WRITE_LATENCY-1 register stages; array updated at edge
//    n+WRITE_LATENCY-1 (WL=1 -> commit at sampling edge).
//  - Read: array read at edge n (read-old: a commit on the same edge is not visible); data plus
//    registered bank select pass READ_LATENCY-1 further stages; bank select delayed in lockstep
//    drives the return mux. o_dout*/o_valid* update after edge n+READ_LATENCY-1.
//  - Full throughput: one request per port per cycle, any mix of banks; returns in order.
//  - o_dout* holds last read data when o_valid*=0; no new read -> o_valid*=0 next cycle.
//  - Ports A and B may access same bank, same or different offset, on same cycle (true DP).
//  - Write/write same address same commit edge: port A data wins; o_wr_collision=1 for the
//    cycle after that edge. Different addresses: both commit, no flag.
//  - A read and a write hitting same address on same edge: read returns pre-write data.
//  - i_en*=0: port pipeline stage carries a bubble; no array access, no valid.
//  - Reset (async assert, sync-to-clock deassert by integrator): all pipeline valids cleared,
//    o_douta=o_doutb=0, o_valida=o_validb=0, o_wr_collision=0. Writes still in pipeline are
//    dropped (never committed); reads in flight never return. Array contents not reset.
//  - Address wrap: none; every ADDR_WIDTH value maps to exactly one bank/offset.
// TESTING  (ADDR_WIDTH=12, DATA_WIDTH=8, NUM_BANKS=4, RL=3, WL=3)
//  1 A write 0x123<-0xA5, idle 3, A read 0x123 at edge n -> o_douta=0xA5, o_valida=1 only after
//    edge n+2.
//  2 B writes 0x000<-0x11,0x400<-0x22,0x800<-0x33,0xC00<-0x44; A reads all four back-to-back ->
//    o_valida high 4 consecutive cycles, data 0x11,0x22,0x33,0x44 (distinct banks, same offset).
//  3 A and B write 0x7FF same cycle, A=0x55 B=0xAA -> o_wr_collision 1-cycle pulse; later read
//    0x7FF returns 0x55. Same-cycle writes to 0x7FF/0x7FE -> no pulse, both readable.
//  4 Preload 0x200<-0x01; A write 0x200<-0x02 and B read 0x200 landing on commit edge ->
//    o_doutb=0x01; next B read -> 0x02.
//  5 Preload 0x300<-0x01; A write 0x300<-0x9C, assert i_rst 1 cycle later (before commit) ->
//    all outputs 0 during reset; after release A read 0x300 -> 0x01.
//  6 Random concurrent A/B traffic 2000 cycles vs scoreboard model (A-wins, read-old) ->
//    zero mismatches; o_valid count equals issued reads per port.

Source files
------------

// File: rtl/multi_bank_dpram_ctrl.sv
// Multi-bank true dual-port RAM controller: per-port write and read pipelines over NUM_BANKS
// storage arrays, read-old ordering on same-edge read/write, port A wins same-address writes.
module multi_bank_dpram_ctrl #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_BANKS     = 4,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ena,
  input  logic                  i_wea,
  input  logic [ADDR_WIDTH-1:0] i_addra,
  input  logic [DATA_WIDTH-1:0] i_dina,
  output logic [DATA_WIDTH-1:0] o_douta,
  output logic                  o_valida,
  input  logic                  i_enb,
  input  logic                  i_web,
  input  logic [ADDR_WIDTH-1:0] i_addrb,
  input  logic [DATA_WIDTH-1:0] i_dinb,
  output logic [DATA_WIDTH-1:0] o_doutb,
  output logic                  o_validb,
  output logic                  o_wr_collision
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int OFF_BITS  = ADDR_WIDTH - BANK_BITS;
  localparam int DEPTH     = 1 << OFF_BITS;
  localparam int NP        = 2;

  typedef logic [BANK_BITS-1:0]  bank_t;
  typedef logic [OFF_BITS-1:0]   off_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    logic  vld;
    bank_t bank;
    off_t  off;
    data_t data;
  } wr_op_t;

  typedef struct packed {
    logic  vld;
    data_t data;
  } rd_op_t;

  // Port index 0 is port A, 1 is port B.
  logic   req_en   [NP];
  logic   req_we   [NP];
  bank_t  req_bank [NP];
  off_t   req_off  [NP];
  data_t  req_din  [NP];
  wr_op_t wr_req   [NP];
  wr_op_t wr_cmt   [NP];

  // Requests seen while reset is held are discarded; this matters when writes commit at the
  // sampling edge.
  always_comb begin
    req_en[0]   = i_ena & ~i_rst;
    req_we[0]   = i_wea;
    req_bank[0] = i_addra[ADDR_WIDTH-1 -: BANK_BITS];
    req_off[0]  = i_addra[OFF_BITS-1:0];
    req_din[0]  = i_dina;
    req_en[1]   = i_enb & ~i_rst;
    req_we[1]   = i_web;
    req_bank[1] = i_addrb[ADDR_WIDTH-1 -: BANK_BITS];
    req_off[1]  = i_addrb[OFF_BITS-1:0];
    req_din[1]  = i_dinb;
    for (int p = 0; p < NP; p++) begin
      wr_req[p] = '{vld: req_en[p] & req_we[p], bank: req_bank[p], off: req_off[p],
                    data: req_din[p]};
    end
  end

  if (WRITE_LATENCY == 1) begin : g_wr_direct
    always_comb begin
      for (int p = 0; p < NP; p++) wr_cmt[p] = wr_req[p];
    end
  end else begin : g_wr_pipe
    localparam int WS = WRITE_LATENCY - 1;
    wr_op_t wr_pipe_d [NP][WS];
    wr_op_t wr_pipe_q [NP][WS];

    always_comb begin
      for (int p = 0; p < NP; p++) begin
        wr_pipe_d[p][0] = wr_req[p];
        for (int s = 1; s < WS; s++) wr_pipe_d[p][s] = wr_pipe_q[p][s-1];
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage shifts on the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int p = 0; p < NP; p++) begin
          for (int s = 0; s < WS; s++) wr_pipe_q[p][s] <= '0;
        end
      end else begin
        wr_pipe_q <= wr_pipe_d;
      end
    end

    always_comb begin
      for (int p = 0; p < NP; p++) wr_cmt[p] = wr_pipe_q[p][WS-1];
    end
  end

  logic [NUM_BANKS-1:0] wr_bank_en [NP];
  logic [NUM_BANKS-1:0] rd_bank_en [NP];
  logic                 wr_same_addr;
  logic                 wr_collision_d;
  logic                 wr_collision_q;

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    wr_same_addr   = wr_cmt[0].vld & wr_cmt[1].vld &
                     (wr_cmt[0].bank == wr_cmt[1].bank) & (wr_cmt[0].off == wr_cmt[1].off);
    wr_collision_d = wr_same_addr;
    for (int p = 0; p < NP; p++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        // Port A wins a same-address commit, so port B's enable is suppressed.
        wr_bank_en[p][b] = wr_cmt[p].vld & (wr_cmt[p].bank == bank_t'(b)) &
                           ~((p == 1) & wr_same_addr);
        rd_bank_en[p][b] = req_en[p] & ~req_we[p] & (req_bank[p] == bank_t'(b));
      end
    end
  end

  data_t bank_mem [NUM_BANKS][DEPTH];

  // NOTE: the storage arrays carry no reset; only pipeline control is reset, so they map to RAM.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_bank_en[1][b]) bank_mem[b][wr_cmt[1].off] <= wr_cmt[1].data;
      if (wr_bank_en[0][b]) bank_mem[b][wr_cmt[0].off] <= wr_cmt[0].data;
    end
  end

  data_t bank_rd_d [NP][NUM_BANKS];
  data_t bank_rd_q [NP][NUM_BANKS];
  bank_t rd_sel_d  [NP];
  bank_t rd_sel_q  [NP];
  logic  rd_vld0_d [NP];
  logic  rd_vld0_q [NP];
  data_t rd_mux    [NP];

  // Array read happens on the request edge; a commit on that same edge lands afterwards.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      rd_vld0_d[p] = |rd_bank_en[p];
      rd_sel_d[p]  = rd_vld0_d[p] ? req_bank[p] : rd_sel_q[p];
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_rd_d[p][b] = rd_bank_en[p][b] ? bank_mem[b][req_off[p]] : bank_rd_q[p][b];
      end
      rd_mux[p] = bank_rd_q[p][rd_sel_q[p]];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < NP; p++) begin
        rd_vld0_q[p] <= 1'b0;
        rd_sel_q[p]  <= '0;
        for (int b = 0; b < NUM_BANKS; b++) bank_rd_q[p][b] <= '0;
      end
      wr_collision_q <= 1'b0;
    end else begin
      rd_vld0_q      <= rd_vld0_d;
      rd_sel_q       <= rd_sel_d;
      bank_rd_q      <= bank_rd_d;
      wr_collision_q <= wr_collision_d;
    end
  end

  rd_op_t rd_out [NP];

  if (READ_LATENCY == 1) begin : g_rd_direct
    always_comb begin
      for (int p = 0; p < NP; p++) rd_out[p] = '{vld: rd_vld0_q[p], data: rd_mux[p]};
    end
  end else begin : g_rd_pipe
    localparam int RS = READ_LATENCY - 1;
    rd_op_t rd_pipe_d [NP][RS];
    rd_op_t rd_pipe_q [NP][RS];

    // Data only advances behind a valid, so the last stage holds the most recent read.
    always_comb begin
      for (int p = 0; p < NP; p++) begin
        rd_pipe_d[p][0] = '{vld:  rd_vld0_q[p],
                            data: rd_vld0_q[p] ? rd_mux[p] : rd_pipe_q[p][0].data};
        for (int s = 1; s < RS; s++) begin
          rd_pipe_d[p][s] = '{vld:  rd_pipe_q[p][s-1].vld,
                              data: rd_pipe_q[p][s-1].vld ? rd_pipe_q[p][s-1].data
                                                          : rd_pipe_q[p][s].data};
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int p = 0; p < NP; p++) begin
          for (int s = 0; s < RS; s++) rd_pipe_q[p][s] <= '0;
        end
      end else begin
        rd_pipe_q <= rd_pipe_d;
      end
    end

    always_comb begin
      for (int p = 0; p < NP; p++) rd_out[p] = rd_pipe_q[p][RS-1];
    end
  end

  assign o_douta        = rd_out[0].data;
  assign o_valida       = rd_out[0].vld;
  assign o_doutb        = rd_out[1].data;
  assign o_validb       = rd_out[1].vld;
  assign o_wr_collision = wr_collision_q;

endmodule
